// File: rtl/shot_flight_ctl_pkg.sv
// Shared screen constants, shot state type and small position helpers for the penalty-shot path.
package shot_flight_ctl_pkg;

    localparam logic [11:0] HOR_PIXELS = 12'd1024;
    localparam logic [11:0] VER_PIXELS = 12'd768;
    localparam logic [11:0] RECT_WIDTH = 12'd64;

    typedef enum logic [1:0] {IDLE, FLIGHT, LANDED} shot_state_t;

    function automatic logic [11:0] clamp_max(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // One pixel toward the target; an axis already there stays put.
    function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] tgt);
        if (cur < tgt) return cur + 12'd1;
        if (cur > tgt) return cur - 12'd1;
        return cur;
    endfunction

endpackage

// File: rtl/shot_step_timer.sv
// Step counter with a decaying period: ticks every period+1 enabled cycles, speeding up to a floor.
module shot_step_timer #(
    parameter logic [17:0] STEP_INIT = 18'd200000,
    parameter logic [17:0] STEP_DEC  = 18'd250,
    parameter logic [17:0] STEP_MIN  = 18'd20000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic step_tick
);

    logic [17:0] cnt_q, cnt_d;
    logic [17:0] period_q, period_d;

    assign step_tick = en && (cnt_q == period_q);

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (load) begin
            cnt_d    = '0;
            period_d = STEP_INIT;
        end else if (en) begin
            if (step_tick) begin
                cnt_d = '0;
                // Saturate at the floor without ever wrapping below it.
                if (period_q > STEP_MIN && (period_q - STEP_MIN) > STEP_DEC) begin
                    period_d = period_q - STEP_DEC;
                end else begin
                    period_d = STEP_MIN;
                end
            end else begin
                cnt_d = cnt_q + 18'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            period_q <= STEP_INIT;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/shot_flight_ctl.sv
// Penalty-shot sequencer: park at the spot, fly one pixel per axis toward a clicked target, hold, return.
// Optional shot counter output shots_taken is built when SHOT_CNT_EN is defined.
module shot_flight_ctl
    import shot_flight_ctl_pkg::*;
#(
    parameter logic [11:0] START_X     = 12'd512,
    parameter logic [11:0] START_Y     = 12'd700,
    parameter logic [17:0] STEP_INIT   = 18'd200000,
    parameter logic [17:0] STEP_DEC    = 18'd250,
    parameter logic [17:0] STEP_MIN    = 18'd20000,
    parameter logic [25:0] HOLD_CYCLES = 26'd32500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        shot_active,
    output logic        shot_done
`ifdef SHOT_CNT_EN
    ,
    output logic [7:0]  shots_taken
`endif
);

    localparam logic [11:0] MAX_X = HOR_PIXELS - RECT_WIDTH;
    localparam logic [11:0] MAX_Y = VER_PIXELS - RECT_WIDTH;

    shot_state_t state_q, state_d;
    logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic [11:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [25:0] hold_q, hold_d;
    logic        done_q, done_d;
    logic        mouse_prev_q, armed_q;
    logic        press, load, en, step_tick;
    logic [11:0] cap_x, cap_y, nxt_x, nxt_y;

    // armed_q masks the first cycle out of reset so a held button is not a press.
    assign press = mouse_left & ~mouse_prev_q & armed_q;
    assign cap_x = clamp_max(mouse_xpos, MAX_X);
    assign cap_y = clamp_max(mouse_ypos, MAX_Y);
    assign nxt_x = step_toward(xpos_q, tgt_x_q);
    assign nxt_y = step_toward(ypos_q, tgt_y_q);

    shot_step_timer #(
        .STEP_INIT (STEP_INIT),
        .STEP_DEC  (STEP_DEC),
        .STEP_MIN  (STEP_MIN)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .en        (en),
        .step_tick (step_tick)
    );

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        load    = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                xpos_d = START_X;
                ypos_d = START_Y;
                if (press) begin
                    tgt_x_d = cap_x;
                    tgt_y_d = cap_y;
                    load    = 1'b1;
                    hold_d  = '0;
                    if (cap_x == xpos_q && cap_y == ypos_q) begin
                        state_d = LANDED;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FLIGHT;
                    end
                end
            end
            FLIGHT: begin
                en = 1'b1;
                if (step_tick) begin
                    xpos_d = nxt_x;
                    ypos_d = nxt_y;
                    if (nxt_x == tgt_x_q && nxt_y == tgt_y_q) begin
                        state_d = LANDED;
                        done_d  = 1'b1;
                        hold_d  = '0;
                    end
                end
            end
            LANDED: begin
                if (press || hold_q == HOLD_CYCLES - 26'd1) begin
                    state_d = IDLE;
                    xpos_d  = START_X;
                    ypos_d  = START_Y;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 26'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            xpos_q       <= START_X;
            ypos_q       <= START_Y;
            tgt_x_q      <= START_X;
            tgt_y_q      <= START_Y;
            hold_q       <= '0;
            done_q       <= 1'b0;
            mouse_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            tgt_x_q      <= tgt_x_d;
            tgt_y_q      <= tgt_y_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            mouse_prev_q <= mouse_left;
            armed_q      <= 1'b1;
        end
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign shot_active = (state_q == FLIGHT);
    assign shot_done   = done_q;

`ifdef SHOT_CNT_EN
    logic [7:0] shots_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shots_q <= '0;
        end else if (done_q && shots_q != 8'd255) begin
            shots_q <= shots_q + 8'd1;
        end
    end

    assign shots_taken = shots_q;
`endif

endmodule
